// File: rtl/jtpopeye_nvram_dump.sv
// Purpose : HPS upload responder; streams a window of game work RAM (hiscore/NVRAM) to the HPS.
// Latency : RD_LAT+1 clk from an accepted ioctl_rd to ioctl_wait low; out-of-window reads answer 8'hFF next clk.
// Backpress: ioctl_wait is high while the CPU bus hold is being acquired and while a RAM read is in flight.
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   uploading                   HPS upload session active (rising edge opens a session)
//   ioctl_addr/ioctl_rd         HPS byte address and one-cycle read strobe
//   ioctl_din/ioctl_wait        returned byte and stall towards the HPS
//   hold/hold_ack               game CPU bus-hold request and acknowledge
//   ram_addr/ram_cs/ram_dout    fixed-latency game RAM read port
//   ioctl_wr/ioctl_data         HPS write strobe/data (used only with the load feature)
//   ram_din/ram_we              game RAM write port (load feature; tied 0 otherwise)
//   busy                        high in every state except IDLE
//
// Optional feature macro: JTPOPEYE_NVRAM_LOAD_EN adds a `downloading` input that can also
// open a session, and lets in-window ioctl_wr strobes write one byte into game RAM.

module jtpopeye_nvram_dump #(
  parameter logic [11:0] BASE     = 12'h000,
  parameter logic [12:0] DUMP_LEN = 13'd1024,
  parameter int          RD_LAT   = 2,
  parameter logic [7:0]  HOLD_TO  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uploading,
`ifdef JTPOPEYE_NVRAM_LOAD_EN
  input  logic        downloading,
`endif
  input  logic [21:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        hold,
  input  logic        hold_ack,
  output logic [11:0] ram_addr,
  output logic        ram_cs,
  input  logic [7:0]  ram_dout,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] READY   = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [21:0] LEN = {9'd0, DUMP_LEN};
  localparam logic [1:0]  LAT = 2'(RD_LAT);

  logic [2:0] state;
  logic       sess;     // session request level (upload, or download when enabled)
  logic       sess_q;   // previous sess, for rising-edge detection
  logic       stop_q;   // session ended while a read was in flight
  logic       in_win;
  logic [7:0] to_cnt;
  logic [1:0] lat_cnt;

`ifdef JTPOPEYE_NVRAM_LOAD_EN
  assign sess = uploading | downloading;
`else
  assign sess    = uploading;
  assign ram_din = 8'h00;
  assign ram_we  = 1'b0;
  logic unused_wr;
  assign unused_wr = ^{ioctl_wr, ioctl_data};
`endif

  assign in_win = ioctl_addr < LEN;
  assign busy   = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      // Seeded from the live level so a session cut by reset is not reopened
      // until the HPS drops and raises the request again.
      sess_q     <= sess;
      stop_q     <= 1'b0;
      to_cnt     <= 8'd0;
      lat_cnt    <= 2'd0;
      ioctl_din  <= 8'hFF;
      ioctl_wait <= 1'b0;
      hold       <= 1'b0;
      ram_cs     <= 1'b0;
      ram_addr   <= 12'd0;
`ifdef JTPOPEYE_NVRAM_LOAD_EN
      ram_din    <= 8'h00;
      ram_we     <= 1'b0;
`endif
    end else begin
      sess_q <= sess;
`ifdef JTPOPEYE_NVRAM_LOAD_EN
      ram_we <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sess && !sess_q) begin
            state      <= REQ;
            hold       <= 1'b1;
            ioctl_wait <= 1'b1;
            to_cnt     <= 8'd0;
          end
        end
        REQ: begin
          if (!sess) begin
            state      <= RELEASE;
            hold       <= 1'b0;
            ioctl_wait <= 1'b0;
          end else if (hold_ack || to_cnt == HOLD_TO) begin
            // On timeout the bus is assumed free; hold stays asserted.
            state      <= READY;
            ioctl_wait <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        READY: begin
          ioctl_wait <= 1'b0;
          if (!sess) begin
            // A strobe coinciding with the end of the session is dropped.
            state <= RELEASE;
            hold  <= 1'b0;
          end else if (ioctl_rd) begin
            if (in_win) begin
              ram_addr   <= BASE + ioctl_addr[11:0];
              ram_cs     <= 1'b1;
              ioctl_wait <= 1'b1;
              lat_cnt    <= 2'd0;
              stop_q     <= 1'b0;
              state      <= READ;
            end else begin
              ioctl_din <= 8'hFF;
            end
          end
`ifdef JTPOPEYE_NVRAM_LOAD_EN
          else if (ioctl_wr && in_win) begin
            ram_addr   <= BASE + ioctl_addr[11:0];
            ram_din    <= ioctl_data;
            ram_we     <= 1'b1;
            ioctl_wait <= 1'b1;
          end
`endif
        end
        READ: begin
          if (!sess) stop_q <= 1'b1;
          if (lat_cnt == LAT) begin
            ioctl_din  <= ram_dout;
            ram_cs     <= 1'b0;
            ioctl_wait <= 1'b0;
            if (stop_q || !sess) begin
              state <= RELEASE;
              hold  <= 1'b0;
            end else begin
              state <= READY;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RELEASE: begin
          hold  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          hold       <= 1'b0;
          ioctl_wait <= 1'b0;
          ram_cs     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_nvram_dump.sv
// Bench for jtpopeye_nvram_dump: randomized reads against a byte-array model of game RAM,
// with a queue of expected responses checked by an independent monitor process.
module tb_jtpopeye_nvram_dump;

  localparam logic [11:0] BASE     = 12'hF80;  // window wraps past 4095
  localparam logic [12:0] DUMP_LEN = 13'd200;
  localparam int          RD_LAT   = 2;
  localparam logic [7:0]  HOLD_TO  = 8'd8;

  logic        clk = 1'b0;
  logic        rst, uploading, ioctl_rd, hold_ack, ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data, ioctl_din, ram_dout, ram_din;
  logic        ioctl_wait, hold, ram_cs, ram_we, busy;
  logic [11:0] ram_addr;
`ifdef JTPOPEYE_NVRAM_LOAD_EN
  logic        downloading;
`endif

  jtpopeye_nvram_dump #(
    .BASE(BASE), .DUMP_LEN(DUMP_LEN), .RD_LAT(RD_LAT), .HOLD_TO(HOLD_TO)
  ) dut (
    .clk(clk), .rst(rst), .uploading(uploading),
`ifdef JTPOPEYE_NVRAM_LOAD_EN
    .downloading(downloading),
`endif
    .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .hold(hold), .hold_ack(hold_ack),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_dout(ram_dout),
    .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data), .ram_din(ram_din),
    .ram_we(ram_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Game RAM: byte array with a RD_LAT-deep read pipeline.
  logic [7:0] mem [4096];
  logic [7:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[RD_LAT-1];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          inwin;
    logic [7:0]  din;
    logic [11:0] addr;
    int          due;
  } exp_t;
  exp_t q[$];

  function automatic logic [21:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 22'd0;
      1:       return 22'(DUMP_LEN) - 22'd1;
      2:       return 22'(DUMP_LEN);
      3:       return 22'($urandom_range(22'h3FFFFF, 32'(DUMP_LEN)));
      default: return 22'($urandom_range(32'(DUMP_LEN) - 1, 0));
    endcase
  endfunction

  // mode: 0 plain, 1 extra strobe during the read, 2 drop uploading during the read
  task automatic do_read(input logic [21:0] a, input int mode);
    exp_t e;
    int   n;
    e.inwin = a < 22'(DUMP_LEN);
    e.addr  = 12'((int'(BASE) + int'(a)) % 4096);
    e.din   = e.inwin ? mem[e.addr] : 8'hFF;
    e.due   = e.inwin ? cyc + 2 + RD_LAT : cyc + 1;
    q.push_back(e);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick;
    ioctl_rd = 1'b0;
    if (e.inwin) begin
      n = 0;
      while (ioctl_wait && n < 16) begin
        if (n == 0 && mode == 1) begin
          ioctl_rd   = 1'b1;
          ioctl_addr = 22'($urandom_range(32'(DUMP_LEN) - 1, 0));
        end
        if (n == 0 && mode == 2) uploading = 1'b0;
        tick;
        ioctl_rd = 1'b0;
        n++;
      end
      chk("read_wait_bound", 32'(ioctl_wait), 0);
    end
  endtask

  // Monitor: compares each response on the cycle the model says it is due.
  initial begin
    exp_t e;
    int   wait_run;
    logic cs_prev;
    wait_run = 0;
    cs_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && ram_cs && !cs_prev && q[0].inwin)
        chk("ram_addr", 32'(ram_addr), 32'(q[0].addr));
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rd_due_cycle", 32'(e.due), 32'(cyc));
        chk("rd_din", 32'(ioctl_din), 32'(e.din));
        chk("rd_wait_low", 32'(ioctl_wait), 0);
        chk("rd_wait_len", 32'(wait_run), e.inwin ? 32'(RD_LAT + 1) : 0);
        if (!e.inwin) chk("oow_ram_cs", 32'(ram_cs), 0);
      end
      wait_run = ioctl_wait ? wait_run + 1 : 0;
      cs_prev  = ram_cs;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] prev;
    rst = 1'b1; uploading = 1'b0; ioctl_rd = 1'b0; hold_ack = 1'b0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
`ifdef JTPOPEYE_NVRAM_LOAD_EN
    downloading = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'hF83] = 8'h5A;  // BASE + 3

    repeat (3) tick;
    chk("rst_ioctl_din", 32'(ioctl_din), 32'hFF);
    chk("rst_ioctl_wait", 32'(ioctl_wait), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_ram_cs", 32'(ram_cs), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din", 32'(ram_din), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick;
    chk("idle_busy", 32'(busy), 0);

    // Session with hold_ack five cycles after the request.
    uploading = 1'b1;
    tick;
    chk("req_hold", 32'(hold), 1);
    chk("req_wait", 32'(ioctl_wait), 1);
    chk("req_busy", 32'(busy), 1);
    repeat (4) tick;
    chk("req_wait_before_ack", 32'(ioctl_wait), 1);
    hold_ack = 1'b1;
    tick;
    hold_ack = 1'b0;
    chk("ack_wait_low", 32'(ioctl_wait), 0);
    chk("ack_hold", 32'(hold), 1);

    do_read(22'd3, 0);
    for (int i = 0; i < 30; i++) begin
      do_read(pick_addr(), ($urandom_range(0, 3) == 0) ? 1 : 0);
      repeat ($urandom_range(0, 2)) tick;
    end
    chk("hold_through_reads", 32'(hold), 1);

    // Upload ends during a read: the read completes, then the bus is released.
    do_read(22'($urandom_range(32'(DUMP_LEN) - 1, 0)), 2);
    n = 0;
    while (hold && n < 2) begin tick; n++; end
    chk("end_hold_released", 32'(hold), 0);
    n = 0;
    while (busy && n < 3) begin tick; n++; end
    chk("end_busy", 32'(busy), 0);

    // Session reaching READY by timeout.
    uploading = 1'b1;
    tick;
    n = 0;
    while (ioctl_wait && n < 40) begin tick; n++; end
    chk("timeout_cycles", 32'(n), 32'(HOLD_TO) + 1);
    chk("timeout_hold", 32'(hold), 1);
    for (int i = 0; i < 10; i++) do_read(pick_addr(), 0);

`ifndef JTPOPEYE_NVRAM_LOAD_EN
    ioctl_addr = 22'd7; ioctl_data = 8'hC3; ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    chk("wr_ignored_we", 32'(ram_we), 0);
    chk("wr_ignored_wait", 32'(ioctl_wait), 0);
    chk("wr_ignored_din", 32'(ram_din), 0);
`endif

    // Upload falls together with a read strobe: the strobe is dropped.
    ioctl_addr = 22'd5; ioctl_rd = 1'b1; uploading = 1'b0;
    tick;
    ioctl_rd = 1'b0;
    chk("drop_ram_cs", 32'(ram_cs), 0);
    chk("drop_wait", 32'(ioctl_wait), 0);
    chk("drop_hold", 32'(hold), 0);
    tick;
    chk("drop_busy", 32'(busy), 0);

    // Strobes in IDLE are ignored.
    prev = ioctl_din;
    ioctl_addr = 22'(DUMP_LEN) + 22'd5; ioctl_rd = 1'b1;
    tick;
    ioctl_addr = 22'd9;
    tick;
    ioctl_rd = 1'b0;
    chk("idle_din", 32'(ioctl_din), 32'(prev));
    chk("idle_ram_cs", 32'(ram_cs), 0);
    chk("idle_wait", 32'(ioctl_wait), 0);

    // Reset in the middle of a read.
    uploading = 1'b1;
    tick;
    hold_ack = 1'b1;
    tick;
    hold_ack = 1'b0;
    ioctl_addr = 22'd3; ioctl_rd = 1'b1;
    tick;
    ioctl_rd = 1'b0;
    chk("pre_rst_ram_cs", 32'(ram_cs), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_hold", 32'(hold), 0);
    chk("mid_rst_wait", 32'(ioctl_wait), 0);
    chk("mid_rst_ram_cs", 32'(ram_cs), 0);
    chk("mid_rst_din", 32'(ioctl_din), 32'hFF);
    chk("mid_rst_busy", 32'(busy), 0);
    uploading = 1'b0;
    tick;
    chk("post_rst_busy", 32'(busy), 0);

`ifdef JTPOPEYE_NVRAM_LOAD_EN
    downloading = 1'b1;
    tick;
    hold_ack = 1'b1;
    tick;
    hold_ack = 1'b0;
    chk("ld_ready", 32'(ioctl_wait), 0);
    ioctl_addr = 22'd7; ioctl_data = 8'hC3; ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    chk("ld_we", 32'(ram_we), 1);
    chk("ld_addr", 32'(ram_addr), 32'(12'hF87));
    chk("ld_din", 32'(ram_din), 32'hC3);
    chk("ld_wait", 32'(ioctl_wait), 1);
    tick;
    chk("ld_we_pulse", 32'(ram_we), 0);
    chk("ld_wait_pulse", 32'(ioctl_wait), 0);
    ioctl_addr = 22'(DUMP_LEN); ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    chk("ld_oow_we", 32'(ram_we), 0);
    downloading = 1'b0;
    repeat (2) tick;
    chk("ld_busy", 32'(busy), 0);
`endif

    repeat (4) tick;
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/jtpopeye_nvram_dump.md
Name: jtpopeye_nvram_dump

Overview:
- HPS-facing upload responder: serves ioctl read requests by streaming a window of game work RAM (hiscore/NVRAM area) back to the MiSTer HPS.
- Complement of the ROM download path. Data flows game → HPS instead of HPS → SDRAM.
- Sits beside jtpopeye_game in the MiSTer top level.
- Stalls the game CPU via a bus-hold handshake while reading, then fetches each requested byte through a fixed-latency RAM port.

Parameters:
- BASE, 12'h000: first game RAM address of the dump window.
- DUMP_LEN, 13'd1024: window length in bytes (1..4096).
- RD_LAT, 2: game RAM read latency in clk cycles (1..3).
- HOLD_TO, 8'd255: cycles to wait for hold_ack before forcing READY (timeout).

Ports:
- clk  in  1  system clock (40 MHz)
- rst  in  1  synchronous, active-high reset
- uploading  in  1  HPS upload session active
- ioctl_addr  in  22  byte address requested by HPS
- ioctl_rd  in  1  one-cycle read strobe
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  high while a read is pending; HPS must not strobe again
- hold  out  1  request game CPU bus hold
- hold_ack  in  1  CPU bus released
- ram_addr  out  12  game RAM address
- ram_cs  out  1  game RAM access enable
- ram_dout  in  8  game RAM read data
- ioctl_wr  in  1  write strobe (used only with the optional feature)
- ioctl_data  in  8  write data (used only with the optional feature)
- ram_din  out  8  game RAM write data (feature)
- ram_we  out  1  game RAM write enable (feature)
- busy  out  1  any state other than IDLE

Behaviour:
- Reset values:
  - ioctl_din = 8'hFF
  - ioctl_wait = 0, hold = 0, ram_cs = 0, ram_we = 0
  - ram_addr = 0, ram_din = 0
  - busy = 0
  - state = IDLE
- Reset mid-operation aborts the session and releases hold in the same cycle the reset is sampled.
- FSM states: IDLE, REQ, READY, READ, RELEASE.
- IDLE:
  - On rising edge of uploading → REQ, hold = 1.
  - ioctl_rd in IDLE is ignored; ioctl_din stays unchanged.
- REQ:
  - ioctl_wait = 1.
  - Timeout counter counts from 0.
  - hold_ack = 1 or counter == HOLD_TO → READY, ioctl_wait = 0.
  - uploading falls → RELEASE.
- READY:
  - ioctl_rd with ioctl_addr < DUMP_LEN:
    - latch ram_addr = BASE + ioctl_addr[11:0], wrapping mod 4096
    - ram_cs = 1, ioctl_wait = 1, latency counter = 0
    - → READ
  - ioctl_rd with ioctl_addr ≥ DUMP_LEN: ioctl_din = 8'hFF next cycle; no wait asserted; stay in READY.
  - uploading falls → RELEASE. If this coincides with ioctl_rd, the strobe is dropped.
- READ:
  - The counter increments each cycle.
  - When it reaches RD_LAT: ioctl_din ← ram_dout, ram_cs = 0, ioctl_wait = 0, → READY.
  - Total read latency = RD_LAT+1 cycles from strobe to ioctl_wait low.
  - ioctl_rd strobes arriving while in READ are ignored.
  - uploading falling in READ: the current read completes, then → RELEASE.
- RELEASE: hold = 0; one cycle later → IDLE.
- busy = (state != IDLE).
- hold stays asserted continuously from REQ through the final READ; no glitches.

Optional Feature:
- Macro: JTPOPEYE_NVRAM_LOAD_EN.
- Defined:
  - The session may also be opened by the downloading input (new port `downloading`, in, 1).
  - In READY, ioctl_wr with ioctl_addr < DUMP_LEN drives one write: ram_addr = BASE + addr, ram_din = ioctl_data, ram_we = 1 for exactly one cycle.
  - ioctl_wait pulses high for that cycle.
  - Writes with ioctl_addr ≥ DUMP_LEN are discarded.
  - downloading falling → RELEASE.
- Undefined:
  - ioctl_wr and ioctl_data are ignored.
  - ram_we is tied 0 and ram_din is tied 0.
  - No `downloading` port exists.

Test Plan:
- Hold with ack: uploading 0→1, hold_ack asserted 5 cycles later → hold=1 on cycle 1, ioctl_wait falls the cycle after ack, state READY.
- Hold timeout: uploading=1, hold_ack stuck 0, HOLD_TO=8 → READY after 9 cycles, hold remains 1.
- In-window read: RAM[BASE+3]=8'h5A, RD_LAT=2, ioctl_rd with addr 3 → ram_addr=BASE+3, ioctl_wait high 3 cycles, then ioctl_din=8'h5A.
- Out-of-window read: addr=DUMP_LEN → ioctl_din=8'hFF, ioctl_wait never asserted, ram_cs stays 0.
- Upload end mid-read: drop uploading during READ → read completes with correct data, then hold=0 within 2 cycles, busy=0.
- Reset mid-session: rst pulsed in READ → next cycle hold=0, ioctl_wait=0, ram_cs=0, ioctl_din=8'hFF, busy=0.
- With JTPOPEYE_NVRAM_LOAD_EN: ioctl_wr with addr 7, data 8'hC3 → single ram_we pulse, ram_addr=BASE+7, ram_din=8'hC3.
